// File: rtl/cpu_pkg.sv
// Shared definitions for the control_unit / alu_datapath pair:
// ALU function codes, instruction field positions and execute FSM states.
package cpu_pkg;

  localparam logic [2:0] ALU_MOVE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  localparam int SRC_HI = 9;
  localparam int SRC_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Codes 101..111 complete without touching registers, result or flags.
  function automatic logic is_nop(input logic [2:0] func);
    return (func > ALU_OR);
  endfunction

endpackage

// File: rtl/reg_group.sv
// Four-entry register file: one combinational read port, masked write of a
// single data word, and a flat observation bus {R3,R2,R1,R0}.
module reg_group #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      we_mask,
  input  logic [DW-1:0]   wdata,
  input  logic [1:0]      raddr,
  output logic [DW-1:0]   rdata,
  output logic [4*DW-1:0] all_q
);

  logic [DW-1:0] regs_r [4];

  // Register storage with synchronous clear and per-entry write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (we_mask[i]) begin
          regs_r[i] <= wdata;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  assign rdata = regs_r[raddr];

  for (genvar g = 0; g < 4; g++) begin : g_obs
    assign all_q[g*DW +: DW] = regs_r[g];
  end

endmodule

// File: rtl/alu_datapath.sv
// Execute stage: latches operands on start, waits LAT cycles, then pulses
// alu_end and commits result/flags/registers on the edge leaving DONE.
module alu_datapath
  import cpu_pkg::*;
#(
  parameter int DW  = 16,
  parameter int LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_group,
  input  logic [2:0]      alu_func,
  input  logic            alu_in_sel,
  input  logic [3:0]      reg_en,
  input  logic [15:0]     ir_out,
  output logic            alu_end,
  output logic            alu_busy,
  output logic [DW-1:0]   result,
  output logic            flag_z,
  output logic            flag_c,
  output logic [4*DW-1:0] rd_data
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_e        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic          accept_s;
  logic          commit_s;

  logic [2:0]    func_r;
  logic [3:0]    mask_r;
  logic [DW-1:0] a_r, b_r;
  logic [DW-1:0] rdata_s, b_sel_s;
  logic [3:0]    we_mask_s;

  logic [DW:0]   add_s;
  logic [DW-1:0] op_res_s;
  logic          op_c_s;
  logic          op_valid_s;

  logic [DW-1:0] result_r;
  logic          z_r, c_r, end_r, busy_r;
  logic          unused_ir_s;

  assign unused_ir_s = ^ir_out[15:10];

  // Next-state decode; en_group is only looked at in IDLE.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (en_group) begin
          state_s  = EXEC;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = EXEC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and execute-latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        cnt_r <= '0;
      end else if (state_r == EXEC) begin
        cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign b_sel_s = alu_in_sel ? {{(DW-8){1'b0}}, ir_out[IMM_HI:IMM_LO]} : rdata_s;

  // Operand and control capture on the accept edge; frozen until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      func_r <= 3'b000;
      mask_r <= 4'b0000;
      a_r    <= '0;
      b_r    <= '0;
    end else if (accept_s) begin
      func_r <= alu_func;
      mask_r <= reg_en;
      a_r    <= rdata_s;
      b_r    <= b_sel_s;
    end else begin
      func_r <= func_r;
      mask_r <= mask_r;
      a_r    <= a_r;
      b_r    <= b_r;
    end
  end

  assign add_s = {1'b0, a_r} + {1'b0, b_r};

  // Combinational op unit on the latched operands.
  always_comb begin
    op_res_s   = '0;
    op_c_s     = 1'b0;
    op_valid_s = 1'b1;
    case (func_r)
      ALU_MOVE: op_res_s = b_r;
      ALU_ADD: begin
        op_res_s = add_s[DW-1:0];
        op_c_s   = add_s[DW];
      end
      ALU_SUB: begin
        op_res_s = a_r - b_r;
        op_c_s   = (a_r < b_r);
      end
      ALU_AND: op_res_s = a_r & b_r;
      ALU_OR:  op_res_s = a_r | b_r;
      default: op_valid_s = 1'b0;
    endcase
  end

  assign commit_s  = (state_r == DONE) && op_valid_s && !is_nop(func_r);
  assign we_mask_s = commit_s ? mask_r : 4'b0000;

  // Result, flags and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      z_r      <= 1'b0;
      c_r      <= 1'b0;
      end_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (commit_s) begin
        result_r <= op_res_s;
        z_r      <= (op_res_s == '0);
        c_r      <= op_c_s;
      end else begin
        result_r <= result_r;
        z_r      <= z_r;
        c_r      <= c_r;
      end
      end_r  <= (state_s == DONE);
      busy_r <= (state_s != IDLE);
    end
  end

  reg_group #(.DW(DW)) u_reg_group (
    .clk     (clk),
    .rst     (rst),
    .we_mask (we_mask_s),
    .wdata   (op_res_s),
    .raddr   (ir_out[SRC_HI:SRC_LO]),
    .rdata   (rdata_s),
    .all_q   (rd_data)
  );

  assign alu_end  = end_r;
  assign alu_busy = busy_r;
  assign result   = result_r;
  assign flag_z   = z_r;
  assign flag_c   = c_r;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath (DW=16, LAT=4).
module tb_alu_datapath;

  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_group;
  logic [2:0]    alu_func;
  logic          alu_in_sel;
  logic [3:0]    reg_en;
  logic [15:0]   ir_out;
  logic          alu_end;
  logic          alu_busy;
  logic [DW-1:0] result;
  logic          flag_z;
  logic          flag_c;
  logic [4*DW-1:0] rd_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_datapath #(.DW(DW), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_group   (en_group),
    .alu_func   (alu_func),
    .alu_in_sel (alu_in_sel),
    .reg_en     (reg_en),
    .ir_out     (ir_out),
    .alu_end    (alu_end),
    .alu_busy   (alu_busy),
    .result     (result),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .rd_data    (rd_data)
  );

  function automatic logic [15:0] reg_at(input int i);
    return rd_data[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one op, returns edges from accept to alu_end, then steps past the commit edge.
  task automatic run_op(input logic [2:0] f, input logic sel, input logic [1:0] src,
                        input logic [7:0] imm, input logic [3:0] mask,
                        output int lat, output logic busy_at_end);
    alu_func   = f;
    alu_in_sel = sel;
    ir_out     = {6'b000000, src, imm};
    reg_en     = mask;
    en_group   = 1'b1;
    tick();
    en_group = 1'b0;
    lat = 0;
    while (alu_end !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    busy_at_end = alu_busy;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en_group = 1'b0; alu_func = 3'b000; alu_in_sel = 1'b0;
    reg_en = 4'b0000; ir_out = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_regs got=%h exp=0", rd_data); end
    checks++;
    if ({result, flag_z, flag_c, alu_end, alu_busy} !== 20'h0) begin
      failures++; $display("FAIL reset_outs got=%h/%b%b%b%b exp=0", result, flag_z, flag_c, alu_end, alu_busy);
    end
  endtask

  task automatic test_move();
    int lat; logic b;
    run_op(3'b000, 1'b1, 2'd0, 8'h02, 4'b0001, lat, b);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL move_latency got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (b !== 1'b1) begin failures++; $display("FAIL busy_at_end got=%b exp=1", b); end
    checks++;
    if (reg_at(0) !== 16'h0002 || result !== 16'h0002 || flag_z !== 1'b0) begin
      failures++; $display("FAIL move_r0 got=%h res=%h z=%b exp=0002 z=0", reg_at(0), result, flag_z);
    end
  endtask

  task automatic test_add();
    int lat; logic b;
    run_op(3'b001, 1'b1, 2'd0, 8'h08, 4'b0001, lat, b);
    checks++;
    if (reg_at(0) !== 16'h000A || flag_c !== 1'b0 || flag_z !== 1'b0) begin
      failures++; $display("FAIL add_basic got=%h c=%b z=%b exp=000a c=0 z=0", reg_at(0), flag_c, flag_z);
    end
    run_op(3'b010, 1'b1, 2'd0, 8'h0B, 4'b0001, lat, b);
    checks++;
    if (reg_at(0) !== 16'hFFFF) begin failures++; $display("FAIL add_setup got=%h exp=ffff", reg_at(0)); end
    run_op(3'b001, 1'b1, 2'd0, 8'h01, 4'b0001, lat, b);
    checks++;
    if (reg_at(0) !== 16'h0000 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
      failures++; $display("FAIL add_wrap got=%h z=%b c=%b exp=0000 z=1 c=1", reg_at(0), flag_z, flag_c);
    end
  endtask

  task automatic test_sub();
    int lat; logic b;
    run_op(3'b000, 1'b1, 2'd0, 8'h04, 4'b0010, lat, b);
    run_op(3'b010, 1'b1, 2'd1, 8'h05, 4'b0010, lat, b);
    checks++;
    if (reg_at(1) !== 16'hFFFF || flag_c !== 1'b1 || flag_z !== 1'b0) begin
      failures++; $display("FAIL sub_borrow got=%h c=%b z=%b exp=ffff c=1 z=0", reg_at(1), flag_c, flag_z);
    end
  endtask

  task automatic test_logic();
    int lat; logic b; logic [63:0] snap;
    run_op(3'b000, 1'b1, 2'd0, 8'hF0, 4'b0001, lat, b);
    run_op(3'b011, 1'b1, 2'd0, 8'h3C, 4'b0100, lat, b);
    checks++;
    if (reg_at(2) !== 16'h0030 || result !== 16'h0030 || reg_at(0) !== 16'h00F0) begin
      failures++; $display("FAIL and_op got=%h res=%h r0=%h exp=0030 r0=00f0", reg_at(2), result, reg_at(0));
    end
    run_op(3'b100, 1'b1, 2'd0, 8'h3C, 4'b1000, lat, b);
    checks++;
    if (reg_at(3) !== 16'h00FC || result !== 16'h00FC) begin
      failures++; $display("FAIL or_op got=%h res=%h exp=00fc", reg_at(3), result);
    end
    snap = rd_data;
    run_op(3'b010, 1'b1, 2'd2, 8'h31, 4'b0000, lat, b);
    checks++;
    if (rd_data !== snap || result !== 16'hFFFF || flag_c !== 1'b1) begin
      failures++; $display("FAIL mask_zero got=%h res=%h c=%b exp=%h res=ffff c=1", rd_data, result, flag_c, snap);
    end
    run_op(3'b111, 1'b1, 2'd0, 8'h01, 4'b1111, lat, b);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL nop_end got=%0d exp=%0d", lat, LAT); end
    checks++;
    if (rd_data !== snap || result !== 16'hFFFF || flag_c !== 1'b1 || flag_z !== 1'b0) begin
      failures++; $display("FAIL nop_hold got=%h res=%h c=%b z=%b exp=%h ffff 1 0", rd_data, result, flag_c, flag_z, snap);
    end
    run_op(3'b011, 1'b1, 2'd0, 8'hFF, 4'b0000, lat, b);
    checks++;
    if (result !== 16'h00F0 || flag_c !== 1'b0) begin
      failures++; $display("FAIL and_clr_c got=%h c=%b exp=00f0 c=0", result, flag_c);
    end
  endtask

  task automatic test_multi();
    int lat; logic b;
    run_op(3'b000, 1'b1, 2'd0, 8'h55, 4'b1010, lat, b);
    checks++;
    if (rd_data !== 64'h0055_0030_0055_00F0) begin
      failures++; $display("FAIL multi_hot got=%h exp=0055003000550 0f0", rd_data);
    end
    run_op(3'b001, 1'b0, 2'd1, 8'h00, 4'b0001, lat, b);
    checks++;
    if (reg_at(0) !== 16'h00AA) begin failures++; $display("FAIL reg_operand got=%h exp=00aa", reg_at(0)); end
  endtask

  task automatic test_back_to_back();
    logic prev; int pulses; int lat;
    alu_func = 3'b001; alu_in_sel = 1'b1; ir_out = 16'h0001; reg_en = 4'b0000;
    en_group = 1'b1;
    prev = 1'b0; pulses = 0;
    // Pulses expected after edges 5 and 11: five idle cycles between them.
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (alu_end !== ((k == 5) || (k == 11))) begin
        failures++; $display("FAIL b2b_edge%0d got=%b exp=%b", k, alu_end, (k == 5) || (k == 11));
      end
      if (prev && alu_end) pulses = pulses + 100;
      if (alu_end) pulses++;
      prev = alu_end;
    end
    en_group = 1'b0;
    checks++;
    if (pulses !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", pulses); end

    run_op(3'b000, 1'b1, 2'd0, 8'h10, 4'b0001, lat, prev);
    alu_func = 3'b001; alu_in_sel = 1'b1; ir_out = 16'h0001; reg_en = 4'b0001;
    en_group = 1'b1;
    tick();
    en_group = 1'b0;
    alu_func = 3'b100; alu_in_sel = 1'b0; ir_out = 16'h01FF; reg_en = 4'b1111;
    lat = 0;
    while (alu_end !== 1'b1 && lat < 16) begin tick(); lat++; end
    tick();
    checks++;
    if (lat !== LAT || reg_at(0) !== 16'h0011 || result !== 16'h0011 || reg_at(1) !== 16'h0055) begin
      failures++; $display("FAIL frozen_ops got=lat%0d r0=%h res=%h r1=%h exp=lat4 0011 0011 0055",
                           lat, reg_at(0), result, reg_at(1));
    end
    alu_func = 3'b000; alu_in_sel = 1'b0; ir_out = 16'h0000; reg_en = 4'b0000;
  endtask

  task automatic test_rst_abort();
    int lat; logic b; int seen;
    alu_func = 3'b000; alu_in_sel = 1'b1; ir_out = 16'h0077; reg_en = 4'b1111;
    en_group = 1'b1;
    tick();
    en_group = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (alu_busy !== 1'b0 || alu_end !== 1'b0 || rd_data !== 64'h0 || result !== 16'h0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      failures++; $display("FAIL abort_state got=busy%b end%b regs%h res%h exp=all zero", alu_busy, alu_end, rd_data, result);
    end
    run_op(3'b000, 1'b1, 2'd0, 8'h09, 4'b0100, lat, b);
    checks++;
    if (lat !== LAT || rd_data !== 64'h0000_0009_0000_0000) begin
      failures++; $display("FAIL restart got=lat%0d regs%h exp=lat4 0000000900000000", lat, rd_data);
    end
    rst = 1'b1; en_group = 1'b1;
    tick();
    rst = 1'b0; en_group = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (alu_end === 1'b1 || alu_busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0 || rd_data !== 64'h0) begin
      failures++; $display("FAIL rst_wins got=active%0d regs%h exp=0 0", seen, rd_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_move();
    test_add();
    test_sub();
    test_logic();
    test_multi();
    test_back_to_back();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
